instr_fetch_unit: RTL and testbench

Fetch stage sitting directly downstream of the PC register. It takes the current PC and issues a read to an instruction memory with variable latency. It holds the returned instruction for decode and tells the PC register when it may advance (PCEnable), so the PC/PCPlus4/PCTarget/PCNextMux path only updates once the current instruction has been consumed. It also detects misaligned PCs and memory timeouts.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory read per PC and holds the word for decode.
// Advances the PC register only when decode consumes; flags misaligned PCs and timeouts.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_NOP      = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrAccept,
    output logic        PCEnable,
    output logic        FetchFault
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          misaligned;
    logic          expired;

    assign misaligned = |PC[1:0];
    // count holds the number of completed wait cycles, so the current cycle is count+1
    assign expired    = count >= CNT_LAST;
    assign mem_addr   = PC;
    assign mem_req    = !reset && (state == S_REQ) && !misaligned && !Flush;
    assign PCEnable   = !reset && (state == S_HOLD) && InstrAccept && !Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            Instr      <= RESET_NOP;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
            FetchFault <= 1'b0;
            count      <= '0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (misaligned) begin
                        state      <= S_FAULT;
                        FetchFault <= 1'b1;
                    end else if (mem_req && mem_ready) begin
                        InstrPC <= PC;
                        count   <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count != CNT_MAX) count <= count + CW'(1);
                    if (mem_rvalid && !Flush) begin
                        Instr      <= mem_rdata;
                        InstrValid <= 1'b1;
                        state      <= S_HOLD;
                    end else if (mem_rvalid) begin
                        state <= S_REQ;
                    end else if (Flush) begin
                        state <= S_DRAIN;
                    end else if (expired) begin
                        state      <= S_FAULT;
                        FetchFault <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (Flush || InstrAccept) begin
                        InstrValid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (count != CNT_MAX) count <= count + CW'(1);
                    if (mem_rvalid) begin
                        state <= S_REQ;
                    end else if (expired) begin
                        state      <= S_FAULT;
                        FetchFault <= 1'b1;
                    end
                end
                S_FAULT: begin
                    FetchFault <= 1'b1;
                    InstrValid <= 1'b0;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder and PC register live here,
// and every fetch is checked at transaction level against the bench's own expectations.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic        Flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrAccept;
    logic        PCEnable;
    logic        FetchFault;

    int          nvec;
    int          nerr;
    logic [31:0] exp_instr;

    instr_fetch_unit #(
        .TIMEOUT_CYCLES(16),
        .RESET_NOP     (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Flush      (Flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrAccept(InstrAccept),
        .PCEnable   (PCEnable),
        .FetchFault (FetchFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Flush       = 1'b0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        InstrAccept = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        idle_inputs();
        PC    = pc;
        reset = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        exp_instr = NOP;
    endtask

    // One complete fetch: optional ready stall, response latency, decode stall, accept.
    task automatic fetch_one(input int rdy_dly, input int lat, input int stall,
                             input logic [31:0] data, input bit jump);
        logic [31:0] pc0;
        pc0 = PC;
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_ready = (i == rdy_dly);
            #1;
            nvec++;
            if ({mem_req, mem_addr} !== {1'b1, pc0}) begin
                nerr++;
                $display("FAIL req_issue: got %h want %h", {mem_req, mem_addr}, {1'b1, pc0});
            end
            tick();
        end
        mem_ready = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            mem_rvalid = (i == lat);
            mem_rdata  = (i == lat) ? data : $urandom;
            #1;
            nvec++;
            if ({mem_req, InstrValid, FetchFault} !== 3'b000) begin
                nerr++;
                $display("FAIL wait_cycle%0d: req/valid/fault got %b want 000", i,
                         {mem_req, InstrValid, FetchFault});
            end
            tick();
        end
        mem_rvalid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            nvec++;
            if ({InstrValid, Instr, InstrPC, PCEnable, mem_req} !== {1'b1, data, pc0, 2'b00}) begin
                nerr++;
                $display("FAIL hold_stall%0d: got %h want %h", i,
                         {InstrValid, Instr, InstrPC, PCEnable, mem_req},
                         {1'b1, data, pc0, 2'b00});
            end
            tick();
        end
        InstrAccept = 1'b1;
        #1;
        nvec++;
        if ({PCEnable, InstrValid, Instr, InstrPC} !== {2'b11, data, pc0}) begin
            nerr++;
            $display("FAIL accept: got %h want %h", {PCEnable, InstrValid, Instr, InstrPC},
                     {2'b11, data, pc0});
        end
        tick();
        InstrAccept = 1'b0;
        exp_instr   = data;
        PC          = jump ? ($urandom & 32'hFFFF_FFFC) : pc0 + 32'd4;
        #1;
        nvec++;
        if ({PCEnable, InstrValid, mem_req, mem_addr} !== {3'b001, PC}) begin
            nerr++;
            $display("FAIL next_req: got %h want %h", {PCEnable, InstrValid, mem_req, mem_addr},
                     {3'b001, PC});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        PC          = '0;
        reset       = 1'b1;
        mem_ready   = 1'b1;
        mem_rvalid  = 1'b1;
        InstrAccept = 1'b1;
        tick();
        #1;
        nvec++;
        if ({mem_req, PCEnable} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_gating: req/pcen got %b want 00", {mem_req, PCEnable});
        end
        tick();
        idle_inputs();
        reset     = 1'b0;
        exp_instr = NOP;
        #1;
        nvec++;
        if ({Instr, InstrPC, InstrValid, FetchFault, mem_req} !== {NOP, 32'd0, 3'b001}) begin
            nerr++;
            $display("FAIL reset_values: got %h want %h",
                     {Instr, InstrPC, InstrValid, FetchFault, mem_req}, {NOP, 32'd0, 3'b001});
        end
    endtask

    task automatic test_basic();
        fetch_one(0, 1, 0, 32'h00500093, 1'b0);
    endtask

    task automatic test_stall();
        fetch_one(0, 4, 5, 32'h00A00113, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            fetch_one($urandom_range(0, 3), $urandom_range(1, 16), $urandom_range(0, 4),
                      $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_flush();
        logic [31:0] pc0;
        logic [31:0] d;
        pc0 = PC;
        Flush     = 1'b1;
        mem_ready = 1'b1;
        #1;
        nvec++;
        if (mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL flush_gates_req: got %b want 0", mem_req);
        end
        tick();
        idle_inputs();
        #1;
        nvec++;
        if ({mem_req, mem_addr} !== {1'b1, pc0}) begin
            nerr++;
            $display("FAIL flush_req_stays: got %h want %h", {mem_req, mem_addr}, {1'b1, pc0});
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        Flush     = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mem_rvalid = (i == 3);
            mem_rdata  = 32'hDEADBEEF;
            #1;
            nvec++;
            if ({InstrValid, mem_req} !== 2'b00) begin
                nerr++;
                $display("FAIL drain_cycle%0d: valid/req got %b want 00", i, {InstrValid, mem_req});
            end
            tick();
            Flush = 1'b0;
        end
        idle_inputs();
        #1;
        nvec++;
        if ({InstrValid, Instr, mem_req, mem_addr} !== {1'b0, exp_instr, 1'b1, pc0}) begin
            nerr++;
            $display("FAIL drain_discard: got %h want %h", {InstrValid, Instr, mem_req, mem_addr},
                     {1'b0, exp_instr, 1'b1, pc0});
        end
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        Flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if ({InstrValid, Instr, mem_req, mem_addr} !== {1'b0, exp_instr, 1'b1, pc0}) begin
            nerr++;
            $display("FAIL flush_with_rvalid: got %h want %h",
                     {InstrValid, Instr, mem_req, mem_addr}, {1'b0, exp_instr, 1'b1, pc0});
        end
        d         = $urandom;
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid  = 1'b0;
        Flush       = 1'b1;
        InstrAccept = 1'b1;
        #1;
        nvec++;
        if ({PCEnable, InstrValid, Instr} !== {2'b01, d}) begin
            nerr++;
            $display("FAIL flush_over_accept: got %h want %h", {PCEnable, InstrValid, Instr},
                     {2'b01, d});
        end
        tick();
        idle_inputs();
        exp_instr = d;
        #1;
        nvec++;
        if ({InstrValid, PCEnable, mem_req, mem_addr} !== {3'b001, pc0}) begin
            nerr++;
            $display("FAIL hold_flush_refetch: got %h want %h",
                     {InstrValid, PCEnable, mem_req, mem_addr}, {3'b001, pc0});
        end
    endtask

    task automatic test_timeout();
        fetch_one(0, 16, 0, $urandom, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            #1;
            nvec++;
            if (FetchFault !== (i == 17)) begin
                nerr++;
                $display("FAIL timeout_cycle%0d: fault got %b want %b", i, FetchFault, i == 17);
            end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            Flush       = 1'($urandom_range(0, 1));
            mem_ready   = 1'($urandom_range(0, 1));
            mem_rvalid  = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            InstrAccept = 1'($urandom_range(0, 1));
            PC          = $urandom & 32'hFFFF_FFFC;
            #1;
            nvec++;
            if ({FetchFault, mem_req, InstrValid, PCEnable} !== 4'b1000) begin
                nerr++;
                $display("FAIL fault_sticky%0d: got %b want 1000", i,
                         {FetchFault, mem_req, InstrValid, PCEnable});
            end
            tick();
        end
        do_reset(32'h100);
        #1;
        nvec++;
        if ({FetchFault, mem_req} !== 2'b01) begin
            nerr++;
            $display("FAIL fault_cleared: got %b want 01", {FetchFault, mem_req});
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        Flush     = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            #1;
            if (i >= 16) begin
                nvec++;
                if (FetchFault !== (i == 17)) begin
                    nerr++;
                    $display("FAIL drain_timeout%0d: fault got %b want %b", i, FetchFault, i == 17);
                end
            end
            tick();
            Flush = 1'b0;
        end
    endtask

    task automatic test_misaligned();
        do_reset(32'h200);
        PC = 32'h16AB2D12;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nvec++;
            if ({mem_req, FetchFault} !== {1'b0, i != 0}) begin
                nerr++;
                $display("FAIL misaligned%0d: req/fault got %b want %b", i, {mem_req, FetchFault},
                         {1'b0, i != 0});
            end
            tick();
        end
        do_reset(32'h16AB2D10);
        #1;
        nvec++;
        if (FetchFault !== 1'b0) begin
            nerr++;
            $display("FAIL misaligned_recover: fault got %b want 0", FetchFault);
        end
        fetch_one(1, 2, 1, 32'h00100073, 1'b0);
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        nvec++;
        if ({mem_req, PCEnable} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_mid_gating: got %b want 00", {mem_req, PCEnable});
        end
        tick();
        reset      = 1'b0;
        exp_instr  = NOP;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if ({InstrValid, Instr, InstrPC, mem_req} !== {1'b0, NOP, 32'd0, 1'b1}) begin
            nerr++;
            $display("FAIL stale_rvalid: got %h want %h", {InstrValid, Instr, InstrPC, mem_req},
                     {1'b0, NOP, 32'd0, 1'b1});
        end
        fetch_one(0, 3, 2, $urandom, 1'b1);
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1'b1;
        PC    = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_flush();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
